register_file_flags: RTL and testbench
======================================

Name: register_file_flags

Overview:
- Architectural register file for the 16-bit CPU, plus a status-flag register.
- Sits directly upstream and downstream of the ALU-with-shift-ops stage:
  - supplies operands A and B on two read ports;
  - takes the ALU Result back on one write port;
  - captures the ALU Zero, Overflow and CarryOut outputs into a sticky flags register for later branch use.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 16, register and data width in bits.
- ADDR_W, 3, register address width; number of registers = 2**ADDR_W = 8.

Ports:
- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  synchronous, active-high; clears all registers and flags.
- RA1  input  ADDR_W  read port 1 address (drives ALU A).
- RA2  input  ADDR_W  read port 2 address (drives ALU B).
- RD1  output  DATA_W  read port 1 data.
- RD2  output  DATA_W  read port 2 data.
- RegWrite  input  1  write enable for port W.
- WA  input  ADDR_W  write address.
- WD  input  DATA_W  write data (ALU Result or memory data).
- FlagWrite  input  1  capture enable for the flag inputs.
- ZeroIn  input  1  ALU Zero.
- OverflowIn  input  1  ALU Overflow.
- CarryIn  input  1  ALU CarryOut.
- FlagZ  output  1  registered Zero flag.
- FlagV  output  1  registered Overflow flag.
- FlagC  output  1  registered Carry flag.
- WriteCount  output  8  number of committed writes since reset; wraps 255 -> 0.

Behaviour:
- Reset:
  - synchronous, active-high, evaluated on the rising edge of Clock;
  - sets all registers, FlagZ/V/C and WriteCount to 0.
  - Reset takes priority over RegWrite and FlagWrite in the same cycle: no write commits.
- Reads:
  - combinational, zero-cycle latency: RD1 = reg[RA1], RD2 = reg[RA2].
  - If RAx == 0, RDx = 0 always.
- Write:
  - on a rising edge with RegWrite=1, Reset=0 and WA != 0: reg[WA] <= WD, and WriteCount increments by 1.
  - RegWrite=1 with WA == 0 is silently ignored: no state change, no count.
- Write-through bypass:
  - if RegWrite=1, WA != 0 and WA == RAx in the same cycle, RDx = WD combinationally (new data, not old).
  - Both ports may bypass at once when RA1 == RA2 == WA.
- Flags:
  - on a rising edge with FlagWrite=1 and Reset=0: FlagZ <= ZeroIn, FlagV <= OverflowIn, FlagC <= CarryIn.
  - With FlagWrite=0 the flags hold (sticky).
  - Flag outputs are registered, one cycle after capture; there is no flag bypass.
- Independence: RegWrite and FlagWrite are independent and may both be active in the same cycle.
- Counter: WriteCount is an 8-bit unsigned counter; wrap-around from 255 to 0 is required, with no saturation.
- Reset mid-operation: a Reset asserted during any write cycle discards that write; the register keeps the value 0.
- Undefined inputs: X on RA/WA with enables low must not corrupt state.

Decomposition:
- Shared package/header:
  - DATA_W, ADDR_W;
  - the ZERO_REG address constant (0);
  - flag bit positions (Z=0, V=1, C=2) for a packed flags view used by branch logic.
- One natural sub-module: flag_register (3-bit enabled register with synchronous reset).
- Register array, bypass muxes and counter stay in the top module.

Test Plan:
- Reset then read:
  - assert Reset 2 cycles, then RA1=3, RA2=7 -> RD1=0x0000, RD2=0x0000;
  - FlagZ/V/C=0, WriteCount=0.
- Write/read:
  - RegWrite=1, WA=5, WD=0xBEEF, one edge; next cycle RA1=5 -> RD1=0xBEEF, WriteCount=1.
- Zero register:
  - RegWrite=1, WA=0, WD=0x1234; RA1=0 -> RD1=0x0000 before and after the edge, WriteCount unchanged.
- Bypass:
  - reg2=0x1111; same cycle RegWrite=1, WA=2, WD=0x2222, RA1=RA2=2 -> RD1=RD2=0x2222 before the edge.
- Flags:
  - FlagWrite=1, ZeroIn=1, OverflowIn=0, CarryIn=1 -> after the edge FlagZ=1, FlagV=0, FlagC=1;
  - FlagWrite=0 with inputs changed -> flags hold.
- Reset priority and wrap:
  - Reset=1 with RegWrite=1, WA=4, WD=0xFFFF -> reg4=0, WriteCount=0;
  - 256 valid writes to WA=1 -> WriteCount returns to 0.

Source files
------------

// File: rtl/register_file_flags_pkg.sv
// Shared widths, the hardwired zero-register address and the packed flag layout
// used by the register file and by downstream branch logic.
package register_file_flags_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned FLAGS_W  = 3;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 2;

    typedef logic [FLAGS_W-1:0] flags_t;

    function automatic flags_t pack_flags(input logic z, input logic v, input logic c);
        flags_t f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/register_file_flags_if.sv
// Operand/writeback/flag bundle between the datapath (master) and the register file (slave).
interface register_file_flags_if;
    import register_file_flags_pkg::*;

    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              reg_write;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              flag_write;
    logic              zero_in;
    logic              overflow_in;
    logic              carry_in;
    logic              flag_z;
    logic              flag_v;
    logic              flag_c;
    logic [7:0]        write_count;

    modport master (
        output ra1, ra2, reg_write, wa, wd, flag_write, zero_in, overflow_in, carry_in,
        input  rd1, rd2, flag_z, flag_v, flag_c, write_count
    );

    modport slave (
        input  ra1, ra2, reg_write, wa, wd, flag_write, zero_in, overflow_in, carry_in,
        output rd1, rd2, flag_z, flag_v, flag_c, write_count
    );

endinterface

// File: rtl/register_file_flags_flag_register.sv
// Enabled status-flag register with synchronous active-high reset; holds when disabled.
module flag_register
    import register_file_flags_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  flags_t d_i,
    output flags_t q_o
);

    flags_t flags_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else if (en_i) begin
            flags_q <= d_i;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/register_file_flags.sv
// 8 x 16-bit register file (r0 reads as zero) with write-through bypass, a sticky
// Z/V/C flag register and a wrapping count of committed writes.
module register_file_flags
    import register_file_flags_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    register_file_flags_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [7:0]        write_count_q;
    logic              wr_en;
    flags_t            flags_d;
    flags_t            flags_q;

    // Writes to r0 are dropped entirely, so they neither land nor count.
    assign wr_en = bus.reg_write && (bus.wa != ZERO_REG);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else if (wr_en) begin
            regs_q[bus.wa] <= bus.wd;
            write_count_q  <= write_count_q + 8'd1;
        end
    end

    always_comb begin
        bus.rd1 = '0;
        bus.rd2 = '0;
        if (bus.ra1 != ZERO_REG) begin
            bus.rd1 = (wr_en && (bus.wa == bus.ra1)) ? bus.wd : regs_q[bus.ra1];
        end
        if (bus.ra2 != ZERO_REG) begin
            bus.rd2 = (wr_en && (bus.wa == bus.ra2)) ? bus.wd : regs_q[bus.ra2];
        end
    end

    assign flags_d = pack_flags(bus.zero_in, bus.overflow_in, bus.carry_in);

    flag_register u_flag_register (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (bus.flag_write),
        .d_i   (flags_d),
        .q_o   (flags_q)
    );

    assign bus.flag_z      = flags_q[FLAG_Z];
    assign bus.flag_v      = flags_q[FLAG_V];
    assign bus.flag_c      = flags_q[FLAG_C];
    assign bus.write_count = write_count_q;

endmodule

// File: tb/tb_register_file_flags.sv
// Directed bench: a behavioural register-file model checked every cycle, plus literal
// expectations from hand-worked vectors.
module tb_register_file_flags;
    import register_file_flags_pkg::*;

    logic clk;
    logic rst;
    register_file_flags_if bus ();

    register_file_flags dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model state: what the register file must hold according to its rules.
    logic [15:0] m_regs [8];
    logic [7:0]  m_count;
    logic        m_z, m_v, m_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] ra);
        if (ra == 3'd0) return 16'h0000;
        if (bus.reg_write && bus.wa != 3'd0 && bus.wa == ra) return bus.wd;
        return m_regs[ra];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
            m_count <= 8'd0;
            m_z <= 1'b0;
            m_v <= 1'b0;
            m_c <= 1'b0;
        end else begin
            if (bus.reg_write === 1'b1 && bus.wa != 3'd0) begin
                m_regs[bus.wa] <= bus.wd;
                m_count <= m_count + 8'd1;
            end
            if (bus.flag_write === 1'b1) begin
                m_z <= bus.zero_in;
                m_v <= bus.overflow_in;
                m_c <= bus.carry_in;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_rd1", 32'(bus.rd1), 32'(model_read(bus.ra1)));
            check("model_rd2", 32'(bus.rd2), 32'(model_read(bus.ra2)));
            check("model_flags", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c},
                  {29'd0, m_z, m_v, m_c});
            check("model_count", 32'(bus.write_count), 32'(m_count));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.ra1 = 3'd0;
        bus.ra2 = 3'd0;
        bus.reg_write = 1'b0;
        bus.wa = 3'd0;
        bus.wd = 16'h0000;
        bus.flag_write = 1'b0;
        bus.zero_in = 1'b0;
        bus.overflow_in = 1'b0;
        bus.carry_in = 1'b0;

        // Reset then read
        step();
        step();
        rst = 1'b0;
        bus.ra1 = 3'd3;
        bus.ra2 = 3'd7;
        check_en = 1'b1;
        @(negedge clk);
        check("reset_rd1", 32'(bus.rd1), 32'h0);
        check("reset_rd2", 32'(bus.rd2), 32'h0);
        check("reset_flags", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c}, 32'h0);
        check("reset_count", 32'(bus.write_count), 32'h0);

        // Write/read
        step();
        bus.reg_write = 1'b1;
        bus.wa = 3'd5;
        bus.wd = 16'hBEEF;
        step();
        bus.reg_write = 1'b0;
        bus.ra1 = 3'd5;
        @(negedge clk);
        check("write_rd1", 32'(bus.rd1), 32'h0000BEEF);
        check("write_count", 32'(bus.write_count), 32'd1);

        // Zero register write ignored
        step();
        bus.ra1 = 3'd0;
        bus.reg_write = 1'b1;
        bus.wa = 3'd0;
        bus.wd = 16'h1234;
        @(negedge clk);
        check("r0_before", 32'(bus.rd1), 32'h0);
        step();
        bus.reg_write = 1'b0;
        @(negedge clk);
        check("r0_after", 32'(bus.rd1), 32'h0);
        check("r0_count", 32'(bus.write_count), 32'd1);

        // Bypass on both ports
        step();
        bus.reg_write = 1'b1;
        bus.wa = 3'd2;
        bus.wd = 16'h1111;
        step();
        bus.wd = 16'h2222;
        bus.ra1 = 3'd2;
        bus.ra2 = 3'd2;
        @(negedge clk);
        check("bypass_rd1", 32'(bus.rd1), 32'h00002222);
        check("bypass_rd2", 32'(bus.rd2), 32'h00002222);
        step();
        bus.reg_write = 1'b0;
        @(negedge clk);
        check("bypass_commit", 32'(bus.rd1), 32'h00002222);
        check("bypass_count", 32'(bus.write_count), 32'd3);

        // Flags: capture is registered, then sticky
        step();
        bus.flag_write = 1'b1;
        bus.zero_in = 1'b1;
        bus.overflow_in = 1'b0;
        bus.carry_in = 1'b1;
        @(negedge clk);
        check("flag_no_bypass", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c}, 32'h0);
        step();
        bus.flag_write = 1'b0;
        bus.zero_in = 1'b0;
        bus.overflow_in = 1'b1;
        bus.carry_in = 1'b0;
        @(negedge clk);
        check("flag_capture", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c}, 32'b101);
        step();
        @(negedge clk);
        check("flag_hold", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c}, 32'b101);

        // Simultaneous register write and flag capture
        step();
        bus.reg_write = 1'b1;
        bus.wa = 3'd3;
        bus.wd = 16'h00A5;
        bus.flag_write = 1'b1;
        bus.ra1 = 3'd5;
        bus.ra2 = 3'd3;
        step();
        bus.reg_write = 1'b0;
        bus.flag_write = 1'b0;
        @(negedge clk);
        check("dual_rd2", 32'(bus.rd2), 32'h000000A5);
        check("dual_flags", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c}, 32'b010);

        // Unknown addresses with enables low must not disturb state
        step();
        check_en = 1'b0;
        bus.ra1 = 3'bxxx;
        bus.wa = 3'bxxx;
        step();
        step();
        bus.ra1 = 3'd5;
        bus.ra2 = 3'd2;
        bus.wa = 3'd0;
        check_en = 1'b1;
        @(negedge clk);
        check("x_hold_r5", 32'(bus.rd1), 32'h0000BEEF);
        check("x_hold_count", 32'(bus.write_count), 32'd4);

        // Reset beats a same-cycle write
        step();
        bus.reg_write = 1'b1;
        bus.wa = 3'd4;
        bus.wd = 16'h5555;
        step();
        rst = 1'b1;
        bus.wd = 16'hFFFF;
        step();
        rst = 1'b0;
        bus.reg_write = 1'b0;
        bus.ra1 = 3'd4;
        @(negedge clk);
        check("rst_prio_r4", 32'(bus.rd1), 32'h0);
        check("rst_prio_count", 32'(bus.write_count), 32'h0);
        check("rst_prio_flags", {29'd0, bus.flag_z, bus.flag_v, bus.flag_c}, 32'h0);

        // 256 writes wrap the counter
        step();
        bus.ra1 = 3'd1;
        bus.ra2 = 3'd4;
        bus.reg_write = 1'b1;
        bus.wa = 3'd1;
        for (int i = 0; i < 256; i++) begin
            bus.wd = 16'(i);
            if (i == 255) begin
                @(negedge clk);
                check("count_255", 32'(bus.write_count), 32'd255);
            end
            step();
        end
        bus.reg_write = 1'b0;
        @(negedge clk);
        check("wrap_count", 32'(bus.write_count), 32'd0);
        check("wrap_rd1", 32'(bus.rd1), 32'h000000FF);
        step();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
